// File: rtl/std_selector_pkg.sv
// Selector encoding kinds and width helpers, shared by arbiters and the selectors
// they drive.
package std_selector_pkg;

  typedef enum logic [1:0] {
    selector_kind_BINARY,
    selector_kind_VECTOR,
    selector_kind_ONEHOT
  } selector_kind;

  function automatic int unsigned calc_binary_select_width(input int unsigned entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

  function automatic int unsigned calc_select_width(input int unsigned entries,
                                                    input selector_kind kind);
    return (kind == selector_kind_BINARY) ? calc_binary_select_width(entries) : entries;
  endfunction

endpackage

// File: rtl/std_rr_arbiter.sv
// Round-robin arbiter: grants one requester, holds the grant locked until
// acknowledged, then rotates priority past the winner.
module std_rr_arbiter
  import std_selector_pkg::*;
#(
  parameter int unsigned  ENTRIES      = 4,
  parameter selector_kind KIND         = selector_kind_BINARY,
  localparam int unsigned SELECT_WIDTH = calc_select_width(ENTRIES, KIND)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clear,
  input  logic [ENTRIES-1:0]      i_request,
  input  logic                    i_ack,
  output logic                    o_valid,
  output logic [ENTRIES-1:0]      o_grant,
  output logic [SELECT_WIDTH-1:0] o_select
);

  localparam int unsigned PTR_WIDTH = calc_binary_select_width(ENTRIES);

  typedef enum logic {StIdle, StGranted} state_e;

  state_e                  state_q, state_d;
  logic [PTR_WIDTH-1:0]    ptr_q, ptr_d;
  logic [PTR_WIDTH-1:0]    win_q, win_d;
  logic [ENTRIES-1:0]      grant_q, grant_d;
  logic [SELECT_WIDTH-1:0] select_q, select_d;

  // Lowest set bit at or above ptr wins; otherwise lowest set bit below ptr.
  function automatic logic [PTR_WIDTH-1:0] next_winner(input logic [ENTRIES-1:0] req,
                                                       input logic [PTR_WIDTH-1:0] ptr);
    logic [PTR_WIDTH-1:0] win_hi;
    logic [PTR_WIDTH-1:0] win_lo;
    logic                 found_hi;
    win_hi   = '0;
    win_lo   = '0;
    found_hi = 1'b0;
    for (int j = int'(ENTRIES) - 1; j >= 0; j--) begin
      if (req[j]) begin
        if (j >= int'(ptr)) begin
          found_hi = 1'b1;
          win_hi   = PTR_WIDTH'(j);
        end else begin
          win_lo = PTR_WIDTH'(j);
        end
      end
    end
    return found_hi ? win_hi : win_lo;
  endfunction

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    grant_d  = grant_q;
    select_d = select_q;

    unique case (state_q)
      StIdle: begin
        if (|i_request) begin
          state_d = StGranted;
          win_d   = next_winner(i_request, ptr_q);
          grant_d = ENTRIES'(1) << win_d;
          if (KIND == selector_kind_BINARY) begin
            select_d = SELECT_WIDTH'(win_d);
          end else begin
            select_d = SELECT_WIDTH'(grant_d);
          end
        end
      end
      StGranted: begin
        if (i_ack) begin
          state_d  = StIdle;
          ptr_d    = (win_q == PTR_WIDTH'(ENTRIES - 1)) ? '0 : win_q + 1'b1;
          grant_d  = '0;
          select_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Flush overrides both a pending ack and new requests.
    if (i_clear) begin
      state_d  = StIdle;
      ptr_d    = '0;
      grant_d  = '0;
      select_d = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      win_q    <= '0;
      grant_q  <= '0;
      select_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      grant_q  <= grant_d;
      select_q <= select_d;
    end
  end

  assign o_valid  = (state_q == StGranted);
  assign o_grant  = grant_q;
  assign o_select = select_q;

endmodule

// File: tb/tb_std_rr_arbiter.sv
// Bench for std_rr_arbiter: a BINARY and a ONEHOT instance share stimulus; a vector
// table feeds a scoreboard, plus a hand-written async reset sequence.
module tb_std_rr_arbiter;
  import std_selector_pkg::*;

  logic       clk;
  logic       rst;
  logic       clear;
  logic [3:0] request;
  logic       ack;

  logic       valid_bin, valid_oh;
  logic [3:0] grant_bin, grant_oh;
  logic [1:0] sel_bin;
  logic [3:0] sel_oh;

  int checks = 0;
  int passes = 0;

  std_rr_arbiter #(
    .ENTRIES(4),
    .KIND   (selector_kind_BINARY)
  ) u_bin (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_clear  (clear),
    .i_request(request),
    .i_ack    (ack),
    .o_valid  (valid_bin),
    .o_grant  (grant_bin),
    .o_select (sel_bin)
  );

  std_rr_arbiter #(
    .ENTRIES(4),
    .KIND   (selector_kind_ONEHOT)
  ) u_oh (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_clear  (clear),
    .i_request(request),
    .i_ack    (ack),
    .o_valid  (valid_oh),
    .o_grant  (grant_oh),
    .o_select (sel_oh)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       ack;
    logic       clr;
    logic       valid;
    logic [3:0] grant;
    logic [1:0] sel;
  } vec_t;

  typedef struct {
    logic       valid;
    logic [3:0] grant;
    logic [1:0] sel;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_all(input string name, input exp_t e);
    check({name, " valid"}, 32'(valid_bin), 32'(e.valid));
    check({name, " grant"}, 32'(grant_bin), 32'(e.grant));
    check({name, " select"}, 32'(sel_bin), 32'(e.sel));
    check({name, " onehot valid"}, 32'(valid_oh), 32'(e.valid));
    check({name, " onehot select"}, 32'(sel_oh), 32'(e.grant));
  endtask

  function automatic void add(input logic [3:0] req, input logic a, input logic c,
                              input logic v, input logic [3:0] g, input logic [1:0] s);
    vec_t t;
    t.req = req; t.ack = a; t.clr = c; t.valid = v; t.grant = g; t.sel = s;
    vecs.push_back(t);
  endfunction

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic step(input vec_t v, input string name);
    exp_t e;
    request = v.req;
    ack     = v.ack;
    clear   = v.clr;
    e.valid = v.valid;
    e.grant = v.grant;
    e.sel   = v.sel;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      $display("FAIL %s: scoreboard empty, got 0 entries, expected 1", name);
    end else begin
      e = sb.pop_front();
      check_all(name, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time expired, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    exp_t zero;
    vec_t v;
    zero.valid = 1'b0; zero.grant = '0; zero.sel = '0;

    // Round robin over 4'b1010
    add(4'b1010, 0, 0, 1, 4'b0010, 2'd1);
    add(4'b1010, 1, 0, 0, 4'b0000, 2'd0);
    add(4'b1010, 0, 0, 1, 4'b1000, 2'd3);
    add(4'b1010, 1, 0, 0, 4'b0000, 2'd0);
    add(4'b1010, 0, 0, 1, 4'b0010, 2'd1);
    add(4'b1010, 1, 0, 0, 4'b0000, 2'd0);
    // Wrap-around: ptr=0 after requester 3, ptr=3 after requester 2
    add(4'b1000, 0, 0, 1, 4'b1000, 2'd3);
    add(4'b1000, 1, 0, 0, 4'b0000, 2'd0);
    add(4'b1001, 0, 0, 1, 4'b0001, 2'd0);
    add(4'b1001, 1, 0, 0, 4'b0000, 2'd0);
    add(4'b0100, 0, 0, 1, 4'b0100, 2'd2);
    add(4'b0100, 1, 0, 0, 4'b0000, 2'd0);
    add(4'b0011, 0, 0, 1, 4'b0001, 2'd0);
    add(4'b0011, 1, 0, 0, 4'b0000, 2'd0);
    // Grant lock while the request moves away
    add(4'b0100, 0, 0, 1, 4'b0100, 2'd2);
    for (int i = 0; i < 5; i++) add(4'b0001, 0, 0, 1, 4'b0100, 2'd2);
    add(4'b0001, 1, 0, 0, 4'b0000, 2'd0);
    add(4'b0001, 0, 0, 1, 4'b0001, 2'd0);
    add(4'b0001, 1, 0, 0, 4'b0000, 2'd0);
    // Idle: no request holds, ack ignored (ptr stays 1)
    add(4'b0000, 0, 0, 0, 4'b0000, 2'd0);
    add(4'b0000, 1, 0, 0, 4'b0000, 2'd0);
    add(4'b1111, 0, 0, 1, 4'b0010, 2'd1);
    add(4'b1111, 1, 0, 0, 4'b0000, 2'd0);
    // Clear beats ack while granted to requester 2
    add(4'b0100, 0, 0, 1, 4'b0100, 2'd2);
    add(4'b0100, 1, 1, 0, 4'b0000, 2'd0);
    add(4'b0101, 0, 0, 1, 4'b0001, 2'd0);
    add(4'b0101, 1, 0, 0, 4'b0000, 2'd0);
    // Clear beats request in idle and resets ptr from 1 to 0
    add(4'b1111, 0, 1, 0, 4'b0000, 2'd0);
    add(4'b1111, 0, 0, 1, 4'b0001, 2'd0);
    add(4'b1111, 1, 0, 0, 4'b0000, 2'd0);

    rst = 1'b1; clear = 1'b0; request = 4'b0; ack = 1'b0;
    #1;
    check_all("reset", zero);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

    // Async reset mid-grant, then arbitration resumes from ptr=0
    v.req = 4'b0100; v.ack = 0; v.clr = 0; v.valid = 1; v.grant = 4'b0100; v.sel = 2'd2;
    step(v, "pre_reset_grant");
    #3;
    rst = 1'b1;
    #1;
    check_all("async_reset", zero);
    request = 4'b1010;
    #1;
    rst = 1'b0;
    v.req = 4'b1010; v.ack = 0; v.clr = 0; v.valid = 1; v.grant = 4'b0010; v.sel = 2'd1;
    step(v, "post_reset_grant");
    v.req = 4'b1010; v.ack = 1; v.clr = 0; v.valid = 0; v.grant = 4'b0000; v.sel = 2'd0;
    step(v, "post_reset_ack");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
